// File: rtl/dcache_mem_pkg.sv
// dcache_mem_pkg: shared state encoding and sizing constants for the dcache line responder
package dcache_mem_pkg;
  localparam int DATA_W = 32;
  localparam int LINE_WORDS_DEF = 4;
  localparam int BEAT_W = $clog2(LINE_WORDS_DEF);
  typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/dcache_mem_array.sv
// dcache_mem_array: unreset word store with synchronous write and combinational read
module dcache_mem_array
  import dcache_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dcache_line_responder.sv
// dcache_line_responder: memory-side line refill/writeback responder; DCACHE_RSP_PARITY_EN adds rsp_parity, wr_parity, wr_perr
module dcache_line_responder
  import dcache_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_done,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  input  logic              rsp_ready,
  output logic              busy
`ifdef DCACHE_RSP_PARITY_EN
  ,
  output logic              rsp_parity,
  input  logic              wr_parity,
  output logic              wr_perr
`endif
);
  localparam int BW = (LINE_WORDS == LINE_WORDS_DEF) ? BEAT_W : $clog2(LINE_WORDS);
  localparam int CW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(LINE_WORDS - 1);
  localparam logic [CW-1:0] CNT0 = CW'(RD_LATENCY > 0 ? RD_LATENCY - 1 : 0);
  state_t state;
  logic [BW-1:0] beat;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic we;
  assign addr = base | ADDR_W'(beat);
  assign we = state == WRITE && wr_valid;
  assign req_ready = state == IDLE;
  assign wr_ready = state == WRITE;
  assign wr_done = state == DONE;
  assign rsp_valid = state == READ;
  assign rsp_last = rsp_valid && beat == LAST;
  assign rsp_data = rsp_valid ? rd_data : '0;
  assign busy = state != IDLE;
  dcache_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(addr),
    .wdata(wr_data),
    .raddr(addr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      cnt <= '0;
      base <= '0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          base <= req_addr & MASK;
          beat <= '0;
          cnt <= CNT0;
          state <= req_write ? WRITE : (RD_LATENCY == 0 ? READ : WAIT);
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= READ;
        end
        READ: if (rsp_ready) begin
          beat <= beat + BW'(1);
          if (beat == LAST) state <= IDLE;
        end
        WRITE: if (wr_valid) begin
          beat <= beat + BW'(1);
          if (beat == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
`ifdef DCACHE_RSP_PARITY_EN
  assign rsp_parity = rsp_valid & ^rsp_data;
  always_ff @(posedge clk)
    wr_perr <= reset ? 1'b0 : we & (^wr_data ^ wr_parity);
`endif
endmodule
